// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_core
// Purpose  : 8N1 asynchronous serial transmitter. One start bit (low), eight
//            data bits LSB first, one stop bit (high), no parity. A byte is
//            accepted on a tx_start pulse while idle; tx_busy covers the frame.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset (aborts any frame)
//            tx_start - transmit request, sampled every edge
//            tx_data  - byte to send, captured at acceptance
//            tx       - serial line, idles high (registered)
//            tx_busy  - high while a frame is in progress (registered)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_core #(
  parameter int CLK_FREQ = 1_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy
);

  // Cycles per bit; the design expects this to be at least 2.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]       r_idx,   w_idx_nxt;
  logic [7:0]       r_shreg, w_shreg_nxt;
  logic             r_tx,    w_tx_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             w_bit_done;

  assign w_bit_done = (r_cnt == LAST_CNT);
  assign tx         = r_tx;
  assign tx_busy    = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // The tx value for each bit is loaded on the edge that opens the bit, so
  // the line only ever moves on a bit boundary and stays a clean flop output.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;

    case (r_state)
      IDLE: begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        if (tx_start) begin
          w_shreg_nxt = tx_data;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_bit_done) begin
          w_cnt_nxt   = '0;
          w_tx_nxt    = r_shreg[0];
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_tx_nxt    = r_shreg[0];
            w_shreg_nxt = {1'b0, r_shreg[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (w_bit_done) begin
          // tx_busy drops here; a new request is only seen one edge later,
          // once the registered busy flag reads low.
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_core
// Purpose  : Directed self-checking bench for uart_tx_core at default
//            parameters (104 clocks per bit, 1040-clock frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_core;

  localparam int C     = 104;
  localparam int FRAME = 1040;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       tx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_core dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .tx_busy  (tx_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called right after the acceptance edge. Records the line at each mid-bit
  // (bits[0] = start ... bits[9] = stop), counts line changes off a bit
  // boundary, and optionally changes inputs at a given frame offset.
  task automatic run_frame(input int ev_cycle, input logic ev_start,
                           input logic [7:0] ev_data, input bit ev_pulse,
                           output logic [9:0] bits, output int len,
                           output int glitches);
    int   off;
    logic prev;
    bits     = '0;
    glitches = 0;
    off      = 0;
    prev     = tx;
    while (tx_busy === 1'b1 && off < 2000) begin
      if (tx !== prev && (off % C) != 0) glitches++;
      prev = tx;
      if ((off % C) == C / 2 && (off / C) < 10) bits[off / C] = tx;
      if (off == ev_cycle) begin
        tx_start = ev_start;
        tx_data  = ev_data;
      end
      if (ev_pulse && off == ev_cycle + 1) tx_start = 1'b0;
      tick;
      off++;
    end
    if (tx !== prev && (off % C) != 0) glitches++;
    len = off;
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold: tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle: tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
      end
    end
  endtask

  task automatic test_single;
    logic [9:0] bits;
    int len, gl;
    tx_data  = 8'h55;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end
    run_frame(-1, 1'b0, 8'h00, 1'b0, bits, len, gl);
    n_cmp++;
    if (bits !== 10'b1010101010) begin
      n_bad++;
      $display("FAIL single_bits: got %b want %b", bits, 10'b1010101010);
    end
    n_cmp++;
    if (len !== FRAME) begin
      n_bad++;
      $display("FAIL single_len: got %0d want %0d", len, FRAME);
    end
    n_cmp++;
    if (gl !== 0) begin
      n_bad++;
      $display("FAIL single_glitch: got %0d off-boundary changes want 0", gl);
    end
    n_cmp++;
    if (tx !== 1'b1) begin
      n_bad++;
      $display("FAIL single_idle_tx: got %b want 1", tx);
    end
  endtask

  task automatic test_sequence;
    logic [7:0] bytes [2];
    logic [9:0] exp   [2];
    logic [9:0] bits;
    int len, gl;
    bytes[0] = 8'h54; exp[0] = 10'b1010101000;
    bytes[1] = 8'h0A; exp[1] = 10'b1000010100;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (tx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_ready[%0d]: busy=%b want 0", k, tx_busy);
      end
      tx_data  = bytes[k];
      tx_start = 1'b1;
      tick;
      tx_start = 1'b0;
      run_frame(-1, 1'b0, 8'h00, 1'b0, bits, len, gl);
      n_cmp++;
      if (bits !== exp[k]) begin
        n_bad++;
        $display("FAIL seq_bits[%0d]: got %b want %b", k, bits, exp[k]);
      end
      n_cmp++;
      if (len !== FRAME) begin
        n_bad++;
        $display("FAIL seq_len[%0d]: got %0d want %0d", k, len, FRAME);
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic [9:0] bits;
    int len, gl, seen;
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    run_frame(300, 1'b1, 8'hFF, 1'b1, bits, len, gl);
    n_cmp++;
    if (bits !== 10'b1101001010) begin
      n_bad++;
      $display("FAIL ignore_bits: got %b want %b", bits, 10'b1101001010);
    end
    n_cmp++;
    if (len !== FRAME) begin
      n_bad++;
      $display("FAIL ignore_len: got %0d want %0d", len, FRAME);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (tx_busy !== 1'b0 || tx !== 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL ignore_no_second: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits;
    int len, gl;
    tx_data  = 8'h31;
    tx_start = 1'b1;
    tick;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_latency: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end
    run_frame(50, 1'b1, 8'h32, 1'b0, bits, len, gl);
    n_cmp++;
    if (bits !== 10'b1001100010) begin
      n_bad++;
      $display("FAIL b2b_first_bits: got %b want %b", bits, 10'b1001100010);
    end
    n_cmp++;
    if (len !== FRAME) begin
      n_bad++;
      $display("FAIL b2b_first_len: got %0d want %0d", len, FRAME);
    end
    // Exactly one idle edge, then the held request starts the next frame.
    tick;
    tx_start = 1'b0;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_restart: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end
    run_frame(-1, 1'b0, 8'h00, 1'b0, bits, len, gl);
    n_cmp++;
    if (bits !== 10'b1001100100) begin
      n_bad++;
      $display("FAIL b2b_second_bits: got %b want %b", bits, 10'b1001100100);
    end
    n_cmp++;
    if (len !== FRAME) begin
      n_bad++;
      $display("FAIL b2b_second_len: got %0d want %0d", len, FRAME);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int len, gl;
    tx_data  = 8'h00;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    repeat (450) tick;   // inside data bit 3 (offsets 416..519)
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end
    rst = 1'b1;
    tick;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_abort: tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
    end
    rst = 1'b0;
    tick;
    n_cmp++;
    if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_idle: tx=%b busy=%b, want tx=1 busy=0", tx, tx_busy);
    end
    tx_data  = 8'h0D;
    tx_start = 1'b1;
    tick;
    tx_start = 1'b0;
    n_cmp++;
    if (tx !== 1'b0 || tx_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_restart: tx=%b busy=%b, want tx=0 busy=1", tx, tx_busy);
    end
    run_frame(-1, 1'b0, 8'h00, 1'b0, bits, len, gl);
    n_cmp++;
    if (bits !== 10'b1000011010) begin
      n_bad++;
      $display("FAIL mid_bits: got %b want %b", bits, 10'b1000011010);
    end
    n_cmp++;
    if (len !== FRAME || gl !== 0) begin
      n_bad++;
      $display("FAIL mid_len: got len %0d glitches %0d want %0d and 0", len, gl, FRAME);
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    test_reset;
    test_single;
    test_sequence;
    test_ignore_busy;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
